spm_serial_mult: RTL and testbench

//  Parametrised serial/parallel multiplier, next generation of the pad-level SPM user project.

---
 rtl/spm_serial_mult_if.sv | 33 +++
 rtl/spm_serial_mult.sv | 123 ++++++++++++
 tb/tb_spm_serial_mult.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/spm_serial_mult_if.sv
// Handshake and serial data bundle for spm_serial_mult.
// acc_i is present only when SPM_ACC_EN is defined.
interface spm_serial_mult_if #(
    parameter int WIDTH = 16
);
    logic             start_i;
    logic             signed_i;
    logic [WIDTH-1:0] x_i;
    logic             y_i;
`ifdef SPM_ACC_EN
    logic             acc_i;
`endif
    logic             p_o;
    logic             p_valid_o;
    logic             busy_o;
    logic             done_o;

    modport master (
`ifdef SPM_ACC_EN
        output acc_i,
`endif
        output start_i, signed_i, x_i, y_i,
        input  p_o, p_valid_o, busy_o, done_o
    );

    modport slave (
`ifdef SPM_ACC_EN
        input  acc_i,
`endif
        input  start_i, signed_i, x_i, y_i,
        output p_o, p_valid_o, busy_o, done_o
    );
endinterface

// File: rtl/spm_serial_mult.sv
// Serial/parallel multiplier streaming the (WIDTH+YBITS)-bit product LSB first.
// Define SPM_ACC_EN to add a serial addend (acc_i) to the streamed product.
module spm_serial_mult #(
    parameter int WIDTH = 16,
    parameter int YBITS = 16
) (
    input logic              clk_i,
    input logic              rst_ni,
    spm_serial_mult_if.slave bus
);
    localparam int PW = WIDTH + YBITS;
    localparam int CW = $clog2(PW + 1);
    localparam logic [CW-1:0] C_LAST  = CW'(PW - 1);
    localparam logic [CW-1:0] C_YLAST = CW'(YBITS - 1);
    localparam logic [CW-1:0] C_YBITS = CW'(YBITS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_x;
    logic [WIDTH:0]   r_acc;
    logic             r_signed;
    logic             r_yMsb;
    logic             r_p;

    logic             w_accept;
    logic             w_compute;
    logic [CW-1:0]    w_bitIdx;
    logic             w_ybit;
    logic [WIDTH:0]   w_xExt;
    logic [WIDTH:0]   w_accCur;
    logic [WIDTH:0]   w_addend;
    logic [WIDTH+1:0] w_sum;
    logic             w_outBit;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: if (bus.start_i) w_nextState = S_RUN;
            S_RUN:  if (r_cnt == C_LAST) w_nextState = S_IDLE;
            default: w_nextState = S_IDLE;
        endcase
    end

    always_comb begin
        bus.busy_o    = 1'b0;
        bus.p_valid_o = 1'b0;
        bus.done_o    = 1'b0;
        if (r_state == S_RUN) begin
            bus.busy_o    = 1'b1;
            bus.p_valid_o = 1'b1;
            bus.done_o    = (r_cnt == C_LAST);
        end
    end

    assign bus.p_o = r_p;

    // Bit 0 is computed in the accept cycle straight from the inputs; later bits
    // use the captured operand. r_cnt is the index of the bit currently on p_o.
    assign w_accept  = (r_state == S_IDLE) && bus.start_i;
    assign w_compute = w_accept || ((r_state == S_RUN) && (r_cnt != C_LAST));
    assign w_bitIdx  = w_accept ? '0 : r_cnt + CW'(1);
    assign w_ybit    = (w_bitIdx < C_YBITS) ? bus.y_i : (r_signed & r_yMsb);
    assign w_xExt    = w_accept ? {bus.signed_i & bus.x_i[WIDTH-1], bus.x_i} : r_x;
    assign w_accCur  = w_accept ? '0 : r_acc;
    assign w_addend  = w_ybit ? w_xExt : '0;
    assign w_sum     = {w_accCur[WIDTH], w_accCur} + {w_addend[WIDTH], w_addend};

`ifdef SPM_ACC_EN
    logic r_carry;
    logic w_carryCur;

    assign w_carryCur = w_accept ? 1'b0 : r_carry;
    assign w_outBit   = w_sum[0] ^ bus.acc_i ^ w_carryCur;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_carry <= 1'b0;
        end else if (w_compute) begin
            r_carry <= (w_sum[0] & bus.acc_i) | (w_sum[0] & w_carryCur) | (bus.acc_i & w_carryCur);
        end
    end
`else
    assign w_outBit = w_sum[0];
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= '0;
            r_x      <= '0;
            r_acc    <= '0;
            r_signed <= 1'b0;
            r_yMsb   <= 1'b0;
            r_p      <= 1'b0;
        end else begin
            r_p <= w_compute ? w_outBit : 1'b0;
            if (w_accept) begin
                r_x      <= w_xExt;
                r_signed <= bus.signed_i;
                r_cnt    <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_compute) begin
                r_acc <= w_sum[WIDTH+1:1];
            end
            // The last sampled y bit doubles as the sign extension during the flush phase.
            if (w_compute && (w_bitIdx == C_YLAST)) begin
                r_yMsb <= bus.y_i;
            end
        end
    end
endmodule

// File: tb/tb_spm_serial_mult.sv
// Directed testbench for spm_serial_mult (WIDTH=YBITS=16); define SPM_ACC_EN to
// also exercise the serial addend.
module tb_spm_serial_mult;
    localparam int WIDTH = 16;
    localparam int YBITS = 16;
    localparam int PW    = WIDTH + YBITS;

    logic clk    = 1'b0;
    logic rst_ni = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    spm_serial_mult_if #(.WIDTH(WIDTH)) bus ();

    spm_serial_mult #(.WIDTH(WIDTH), .YBITS(YBITS)) dut (
        .clk_i (clk),
        .rst_ni(rst_ni),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Drives one operation starting at the current negedge (cycle T0) and
    // collects the 32 output cycles; ends at the negedge of the done cycle.
    task automatic applyStimulus(input logic [WIDTH-1:0] x, input logic [YBITS-1:0] y,
                                 input logic sgn, input logic [PW-1:0] acc,
                                 input logic holdStart, input logic glitch,
                                 output logic [PW-1:0] prod, output int validCnt,
                                 output int doneCnt, output int doneAt);
        bus.start_i  = 1'b1;
        bus.x_i      = x;
        bus.signed_i = sgn;
        bus.y_i      = y[0];
`ifdef SPM_ACC_EN
        bus.acc_i    = acc[0];
`else
        if (acc != '0) $display("[TB] addend ignored in this build");
`endif
        prod     = '0;
        validCnt = 0;
        doneCnt  = 0;
        doneAt   = -1;
        for (int k = 0; k < PW; k++) begin
            @(negedge clk);
            prod[k] = bus.p_o;
            if (bus.p_valid_o && bus.busy_o) validCnt++;
            if (bus.done_o) begin
                doneCnt++;
                doneAt = k + 1;
            end
            bus.start_i = holdStart;
            if (k + 1 < YBITS) bus.y_i = y[k+1];
            else               bus.y_i = ~y[YBITS-1];
`ifdef SPM_ACC_EN
            bus.acc_i = (k + 1 < PW) ? acc[k+1] : 1'b0;
`endif
            if (glitch && (k == 4 || k == PW - 1)) begin
                bus.start_i  = 1'b1;
                bus.x_i      = ~x;
                bus.signed_i = ~sgn;
            end
        end
    endtask

    task automatic test_reset();
        rst_ni      = 1'b0;
        bus.start_i = 1'b1;
        #12;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy_o); end
        vectors++;
        if (bus.p_valid_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.p_valid_o); end
        vectors++;
        if (bus.done_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b expected 0", bus.done_o); end
        vectors++;
        if (bus.p_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_p: got %b expected 0", bus.p_o); end
        bus.start_i = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_unsigned_max();
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        applyStimulus(16'hFFFF, 16'hFFFF, 1'b0, '0, 1'b0, 1'b0, prod, validCnt, doneCnt, doneAt);
        vectors++;
        if (prod !== 32'hFFFE0001) begin miscompares++; $display("[TB] FAIL umax_product: got %h expected fffe0001", prod); end
        vectors++;
        if (validCnt !== 32) begin miscompares++; $display("[TB] FAIL umax_valid_cycles: got %0d expected 32", validCnt); end
        vectors++;
        if (doneCnt !== 1 || doneAt !== 32) begin
            miscompares++;
            $display("[TB] FAIL umax_done: got count %0d at %0d expected 1 at 32", doneCnt, doneAt);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        vectors++;
        if ({bus.busy_o, bus.p_valid_o, bus.done_o, bus.p_o} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL umax_idle: got %b expected 0000", {bus.busy_o, bus.p_valid_o, bus.done_o, bus.p_o});
        end
    endtask

    task automatic test_signed_modes();
        logic [WIDTH-1:0] xs [6] = '{16'hFFFD, 16'hFFFD, 16'h8000, 16'h8000, 16'h8000, 16'h7FFF};
        logic [YBITS-1:0] ys [6] = '{16'h0005, 16'h0005, 16'h8000, 16'hFFFF, 16'hFFFF, 16'h8000};
        logic             sg [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        logic [PW-1:0]    ex [6] = '{32'hFFFFFFF1, 32'h0004FFF1, 32'h40000000,
                                     32'h00008000, 32'h7FFF8000, 32'hC0008000};
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(xs[i], ys[i], sg[i], '0, 1'b0, 1'b0, prod, validCnt, doneCnt, doneAt);
            vectors++;
            if (prod !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL mode_row%0d: got %h expected %h", i, prod, ex[i]);
            end
            @(negedge clk);
            bus.start_i = 1'b0;
            vectors++;
            if (bus.busy_o !== 1'b0 || bus.p_o !== 1'b0) begin
                miscompares++;
                $display("[TB] FAIL mode_idle%0d: got busy %b p %b expected 0 0", i, bus.busy_o, bus.p_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        applyStimulus(16'h1234, 16'h0000, 1'b0, '0, 1'b1, 1'b0, prod, validCnt, doneCnt, doneAt);
        vectors++;
        if (prod !== 32'h0) begin miscompares++; $display("[TB] FAIL b2b_zero_product: got %h expected 00000000", prod); end
        vectors++;
        if (validCnt !== 32) begin miscompares++; $display("[TB] FAIL b2b_zero_valid: got %0d expected 32", validCnt); end
        @(negedge clk);
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_gap: got busy %b expected 0", bus.busy_o); end
        applyStimulus(16'h0007, 16'h0006, 1'b0, '0, 1'b0, 1'b0, prod, validCnt, doneCnt, doneAt);
        vectors++;
        if (prod !== 32'h0000002A) begin miscompares++; $display("[TB] FAIL b2b_second_product: got %h expected 0000002a", prod); end
        vectors++;
        if (doneCnt !== 1 || doneAt !== 32) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_done: got count %0d at %0d expected 1 at 32", doneCnt, doneAt);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_idle: got busy %b expected 0", bus.busy_o); end
    endtask

    task automatic test_ignored_start();
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        applyStimulus(16'h00A5, 16'h0103, 1'b0, '0, 1'b0, 1'b1, prod, validCnt, doneCnt, doneAt);
        vectors++;
        if (prod !== 32'h0000A6EF) begin miscompares++; $display("[TB] FAIL ign_product: got %h expected 0000a6ef", prod); end
        vectors++;
        if (validCnt !== 32) begin miscompares++; $display("[TB] FAIL ign_busy_cycles: got %0d expected 32", validCnt); end
        vectors++;
        if (doneCnt !== 1 || doneAt !== 32) begin
            miscompares++;
            $display("[TB] FAIL ign_done: got count %0d at %0d expected 1 at 32", doneCnt, doneAt);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        vectors++;
        if (bus.busy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_not_queued: got busy %b expected 0", bus.busy_o); end
    endtask

    task automatic test_reset_abort();
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        int activity = 0;
        bus.start_i  = 1'b1;
        bus.x_i      = 16'hFFFF;
        bus.signed_i = 1'b0;
        bus.y_i      = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            bus.start_i = 1'b0;
        end
        @(negedge clk);
        rst_ni = 1'b0;
        #1;
        vectors++;
        if ({bus.busy_o, bus.p_valid_o, bus.done_o, bus.p_o} !== 4'b0000) begin
            miscompares++;
            $display("[TB] FAIL abort_outputs: got %b expected 0000", {bus.busy_o, bus.p_valid_o, bus.done_o, bus.p_o});
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) activity++;
        end
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0) activity++;
        end
        vectors++;
        if (activity !== 0) begin miscompares++; $display("[TB] FAIL abort_no_done: got %0d active cycles expected 0", activity); end
        applyStimulus(16'h0007, 16'h0006, 1'b0, '0, 1'b0, 1'b0, prod, validCnt, doneCnt, doneAt);
        vectors++;
        if (prod !== 32'h0000002A) begin miscompares++; $display("[TB] FAIL abort_recover: got %h expected 0000002a", prod); end
        @(negedge clk);
        bus.start_i = 1'b0;
    endtask

`ifdef SPM_ACC_EN
    task automatic test_accumulate();
        logic [WIDTH-1:0] xs [3] = '{16'h0002, 16'h0000, 16'hFFFD};
        logic [YBITS-1:0] ys [3] = '{16'h0003, 16'h0000, 16'h0005};
        logic             sg [3] = '{1'b0, 1'b0, 1'b1};
        logic [PW-1:0]    ac [3] = '{32'hFFFFFFFF, 32'h89ABCDEF, 32'h0000000F};
        logic [PW-1:0]    ex [3] = '{32'h00000005, 32'h89ABCDEF, 32'h00000000};
        logic [PW-1:0] prod;
        int validCnt, doneCnt, doneAt;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(xs[i], ys[i], sg[i], ac[i], 1'b0, 1'b0, prod, validCnt, doneCnt, doneAt);
            vectors++;
            if (prod !== ex[i]) begin
                miscompares++;
                $display("[TB] FAIL acc_row%0d: got %h expected %h", i, prod, ex[i]);
            end
            @(negedge clk);
            bus.start_i = 1'b0;
        end
    endtask
`endif

    initial begin
        bus.start_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.x_i      = '0;
        bus.y_i      = 1'b0;
`ifdef SPM_ACC_EN
        bus.acc_i    = 1'b0;
`endif
        $display("[TB] starting spm_serial_mult bench");
        test_reset();
        test_unsigned_max();
        test_signed_modes();
        test_back_to_back();
        test_ignored_start();
        test_reset_abort();
`ifdef SPM_ACC_EN
        test_accumulate();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
